pico_cyc10_qys_led_ctrl: RTL and testbench
==========================================

# pico_cyc10_qys_led_ctrl

Parametrised Avalon-MM output-port controller for the board LED bank, sitting on the PicoRV32 system bus like the existing single-register LED port. It adds per-channel PWM dimming, atomic set/clear, and glitch-free duty updates. All channels share one prescaler and one PWM period counter; each channel has its own duty shadow and active register. Reads are zero-wait-state; `out_port` is fully registered.

## Interface
- `WIDTH`, 8: number of LED channels (1..8).
- `PWM_BITS`, 8: PWM counter and duty width (2..16); period is 2^PWM_BITS ticks.
- `PRESCALE`, 256: clk cycles per PWM tick (≥1).
- `RESET_VALUE`, all ones: reset value of DATA and `out_port`.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `address` in 4: word address.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: combinational read data; unused bits are 0.
- `out_port` out WIDTH: registered LED drive.

## Operation
- Address map:
  - 0 DATA (rw).
  - 1 SET (wo; write-1 sets DATA bits; reads 0).
  - 2 CLEAR (wo; write-1 clears DATA bits; reads 0).
  - 3 MODE (rw; bit ch: 0 = static, 1 = PWM).
  - 4 STATUS (ro; [PWM_BITS-1:0] = pwm_cnt).
  - 5–7 reserved (read 0, writes ignored).
  - 8+ch DUTY[ch] (rw, PWM_BITS wide); for ch ≥ WIDTH, reads 0 and writes are ignored.
- A write occurs when `chipselect && !write_n`. Only the low WIDTH or PWM_BITS bits of `writedata` are used.
- Prescaler `pre_cnt` counts 0..PRESCALE-1 and wraps. `tick` is asserted when `pre_cnt == PRESCALE-1`.
- `pwm_cnt` increments on `tick` and wraps from 2^PWM_BITS-1 to 0. The `wrap` event is `tick && pwm_cnt == max`.
- Duty shadow and active registers:
  - DUTY writes update the shadow only.
  - On `wrap`, every active duty loads from its shadow.
  - Readback returns the shadow.
- Channel level:
  - Static mode: DATA[ch].
  - PWM mode: DATA[ch] & (pwm_cnt < active_duty[ch]). DATA acts as the enable.
  - duty 0 gives constant 0. Full on is achieved with static mode.
- `out_port` is registered from the channel levels every cycle.
- MODE changes take effect on the next `out_port` update and do not wait for `wrap`.
- A DUTY write in the same cycle as `wrap`: the active register loads the old shadow, and the new shadow applies from the following period.

## Timing
- Reset values (cycle after `reset` is sampled high):
  - DATA = RESET_VALUE; `out_port` = RESET_VALUE.
  - MODE = 0.
  - All shadow and active duty registers = 0.
  - `pre_cnt` = 0; `pwm_cnt` = 0.
- `reset` asserted mid-period aborts the period. No pending shadow is transferred.
- Write at edge N updates the register at N; `out_port` reflects it at edge N+1 (1-cycle latency).
- `readdata` is combinational from the current address and register state. A read in the same cycle as a write returns the pre-write value.
- PWM period = PRESCALE × 2^PWM_BITS clk cycles. High time = duty × PRESCALE cycles, starting at `pwm_cnt` 0.
- PRESCALE = 1 gives `tick` every cycle.

## Structure
- Shared package `pico_cyc10_qys_led_pkg`:
  - Address constants ADDR_DATA=0, ADDR_SET=1, ADDR_CLEAR=2, ADDR_MODE=3, ADDR_STATUS=4, ADDR_DUTY_BASE=8.
  - MODE encodings STATIC=0, PWM=1.
- One sub-module: `pico_cyc10_qys_led_pwm_timebase`, containing the prescaler and `pwm_cnt`, with outputs `tick`, `wrap` and `pwm_cnt`.
- Per-channel duty and compare logic sits in a generate loop in the top module.

## Test plan
- Reset with defaults → `out_port` = 8'hFF, `readdata` @0 = 32'h000000FF, MODE and DUTY read 0.
- Write DATA = 8'h0F; SET 8'h30; CLEAR 8'h03 → DATA reads 8'h3C; `out_port` = 8'h3C one cycle after the last write; SET and CLEAR read 0.
- PRESCALE=4, PWM_BITS=4; MODE = 8'h01, DUTY[0] = 4 → after the next `wrap`, `out_port[0]` is high 16 and low 48 of every 64 cycles; other channels stay static.
- DUTY[0] changed from 4 to 12 mid-period → current period keeps 16 high cycles, next period has 48; readback = 12 immediately after the write.
- DUTY write in the `wrap` cycle, and DUTY[0] = 0 → the write applies one period later; duty 0 gives `out_port[0]` constantly 0 even with DATA[0] = 1.
- `reset` asserted mid-period with PWM active, plus a write to address 15 when WIDTH = 4 → all reset values restored and STATUS = 0; the address-15 write is ignored and reads 0.

Source files
------------

// File: rtl/pico_cyc10_qys_led_pkg.sv
// Shared register map and channel mode encodings for the PicoRV32 LED bank controller.
`timescale 1ns/1ps
package pico_cyc10_qys_led_pkg;

    localparam logic [3:0] ADDR_DATA      = 4'd0;
    localparam logic [3:0] ADDR_SET       = 4'd1;
    localparam logic [3:0] ADDR_CLEAR     = 4'd2;
    localparam logic [3:0] ADDR_MODE      = 4'd3;
    localparam logic [3:0] ADDR_STATUS    = 4'd4;
    localparam logic [3:0] ADDR_DUTY_BASE = 4'd8;

    typedef enum logic {
        STATIC = 1'b0,
        PWM    = 1'b1
    } mode_e;

endpackage

// File: rtl/pico_cyc10_qys_led_pwm_timebase.sv
// Shared PWM timebase: clock prescaler feeding a free-running period counter.
`timescale 1ns/1ps
module pico_cyc10_qys_led_pwm_timebase #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 256
) (
    input  logic                clk,
    input  logic                reset,
    output logic                tick,
    output logic                wrap,
    output logic [PWM_BITS-1:0] pwm_cnt
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_cnt;

    // With PRESCALE == 1 the prescaler is pinned at 0 and ticks every cycle.
    assign tick = (pre_cnt == PRE_MAX);
    assign wrap = tick && (pwm_cnt == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick)
                pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pico_cyc10_qys_led_ctrl.sv
// Avalon-MM LED bank with atomic set/clear and per-channel PWM dimming;
// duty writes land in a shadow and are copied to the active compare on period wrap.
`timescale 1ns/1ps
module pico_cyc10_qys_led_ctrl
    import pico_cyc10_qys_led_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               PWM_BITS    = 8,
    parameter int               PRESCALE    = 256,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic                             wr;
    logic [WIDTH-1:0]                 data_q;
    logic [WIDTH-1:0]                 mode_q;
    logic [WIDTH-1:0]                 level;
    logic [WIDTH-1:0][PWM_BITS-1:0]   duty_shadow;
    logic                             tick;
    logic                             wrap;
    logic [PWM_BITS-1:0]              pwm_cnt;
    logic                             unused_bits;

    assign wr = chipselect && !write_n;
    assign unused_bits = ^{tick, writedata};

    pico_cyc10_qys_led_pwm_timebase #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk     (clk),
        .reset   (reset),
        .tick    (tick),
        .wrap    (wrap),
        .pwm_cnt (pwm_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE;
            mode_q <= '0;
        end else if (wr) begin
            case (address)
                ADDR_DATA:  data_q <= writedata[WIDTH-1:0];
                ADDR_SET:   data_q <= data_q | writedata[WIDTH-1:0];
                ADDR_CLEAR: data_q <= data_q & ~writedata[WIDTH-1:0];
                ADDR_MODE:  mode_q <= writedata[WIDTH-1:0];
                default: ;
            endcase
        end
    end

    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_chan
        localparam logic [3:0] DUTY_ADDR = ADDR_DUTY_BASE + 4'(ch);

        logic [PWM_BITS-1:0] shadow;
        logic [PWM_BITS-1:0] active;

        // Non-blocking update lets a write coinciding with wrap miss this period.
        always_ff @(posedge clk) begin
            if (reset) begin
                shadow <= '0;
                active <= '0;
            end else begin
                if (wr && address == DUTY_ADDR)
                    shadow <= writedata[PWM_BITS-1:0];
                if (wrap)
                    active <= shadow;
            end
        end

        assign duty_shadow[ch] = shadow;
        assign level[ch] = data_q[ch] &
                           ((mode_e'(mode_q[ch]) == PWM) ? (pwm_cnt < active) : 1'b1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            out_port <= RESET_VALUE;
        else
            out_port <= level;
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_q);
            ADDR_MODE:   readdata = 32'(mode_q);
            ADDR_STATUS: readdata = 32'(pwm_cnt);
            default: ;
        endcase
        for (int ch = 0; ch < WIDTH; ch++) begin
            if (address == ADDR_DUTY_BASE + 4'(ch))
                readdata = 32'(duty_shadow[ch]);
        end
    end

endmodule

// File: tb/tb_pico_cyc10_qys_led_ctrl.sv
// Directed bench: register-map vector table plus PWM period / reset sequences.
`timescale 1ns/1ps
module tb_pico_cyc10_qys_led_ctrl;

    typedef struct {
        logic [3:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata, readdata4;
    logic [7:0]  out_port;
    logic [3:0]  out_port4;

    int checks = 0;
    int errors = 0;
    vec_t vecs[18];

    always #10 clk = ~clk;

    pico_cyc10_qys_led_ctrl #(.WIDTH(8), .PWM_BITS(4), .PRESCALE(4)) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    pico_cyc10_qys_led_ctrl #(.WIDTH(4), .PWM_BITS(4), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata4), .out_port(out_port4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    // Returns just after the negedge following a pwm_cnt 15 -> 0 transition.
    task automatic sync_period();
        bit seen15 = 1'b0;
        bit found = 1'b0;
        address = 4'd4;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            #1;
            if (readdata == 32'd15) seen15 = 1'b1;
            else if (seen15 && readdata == 32'd0) found = 1'b1;
        end
        check("sync_wrap_seen", 64'(found), 64'd1);
    endtask

    // Samples out_port over one 64-cycle period; optionally writes DUTY[0] at sample wr_at.
    task automatic measure(input int wr_at, input logic [31:0] wdata,
                           output logic [63:0] pat, output logic [31:0] rd_after,
                           output int other_bad);
        pat = '0; rd_after = '0; other_bad = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == wr_at) begin
                address = 4'd8; writedata = wdata; chipselect = 1'b1; write_n = 1'b0;
            end else begin
                chipselect = 1'b0; write_n = 1'b1;
            end
            if (i == wr_at + 1) rd_after = readdata;
            pat[i] = out_port[0];
            if (out_port[7:1] != 7'b1000000) other_bad++;
        end
    endtask

    function automatic logic [63:0] exp_pat(input int duty);
        return (duty == 0) ? 64'd0 : ((64'd1 << (4 * duty)) - 64'd1);
    endfunction

    initial begin
        logic [63:0] pat;
        logic [31:0] rd_after;
        int          other_bad;

        vecs[0]  = '{4'd0, 1'b0, 32'h0,        32'hFF, 8'hFF};
        vecs[1]  = '{4'd3, 1'b0, 32'h0,        32'h00, 8'hFF};
        vecs[2]  = '{4'd8, 1'b0, 32'h0,        32'h00, 8'hFF};
        vecs[3]  = '{4'd0, 1'b1, 32'h0F,       32'hFF, 8'hFF};
        vecs[4]  = '{4'd1, 1'b1, 32'h30,       32'h00, 8'h0F};
        vecs[5]  = '{4'd2, 1'b1, 32'h03,       32'h00, 8'h3F};
        vecs[6]  = '{4'd0, 1'b0, 32'h0,        32'h3C, 8'h3C};
        vecs[7]  = '{4'd1, 1'b0, 32'h0,        32'h00, 8'h3C};
        vecs[8]  = '{4'd2, 1'b0, 32'h0,        32'h00, 8'h3C};
        vecs[9]  = '{4'd5, 1'b1, 32'hFFFFFFFF, 32'h00, 8'h3C};
        vecs[10] = '{4'd5, 1'b0, 32'h0,        32'h00, 8'h3C};
        vecs[11] = '{4'd0, 1'b0, 32'h0,        32'h3C, 8'h3C};
        vecs[12] = '{4'd9, 1'b1, 32'hA5,       32'h00, 8'h3C};
        vecs[13] = '{4'd9, 1'b0, 32'h0,        32'h05, 8'h3C};
        vecs[14] = '{4'd0, 1'b1, 32'hFFFFFF00, 32'h3C, 8'h3C};
        vecs[15] = '{4'd0, 1'b0, 32'h0,        32'h00, 8'h00};
        vecs[16] = '{4'd3, 1'b1, 32'h0000FF00, 32'h00, 8'h00};
        vecs[17] = '{4'd3, 1'b0, 32'h0,        32'h00, 8'h00};

        repeat (3) @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            address = vecs[i].addr; writedata = vecs[i].wdata;
            chipselect = vecs[i].wr; write_n = !vecs[i].wr;
            #1;
            check($sformatf("vec%0d_readdata", i), 64'(readdata), 64'(vecs[i].exp_rd));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_out_port", i), 64'(out_port), 64'(vecs[i].exp_out));
        end
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;

        // PWM on channel 0, channel 7 static on, the rest static off.
        bus_wr(4'd0, 32'h81);
        bus_wr(4'd3, 32'h01);
        bus_wr(4'd8, 32'h04);
        sync_period();

        measure(20, 32'd12, pat, rd_after, other_bad);
        check("p1_duty4_pattern", pat, exp_pat(4));
        check("p1_readback_12", 64'(rd_after), 64'd12);
        check("p1_static_channels", 64'(other_bad), 64'd0);

        measure(62, 32'd0, pat, rd_after, other_bad);
        check("p2_duty12_pattern", pat, exp_pat(12));
        check("p2_static_channels", 64'(other_bad), 64'd0);

        measure(-10, 32'd0, pat, rd_after, other_bad);
        check("p3_wrap_write_deferred", pat, exp_pat(12));

        measure(-10, 32'd0, pat, rd_after, other_bad);
        check("p4_duty0_always_low", pat, exp_pat(0));
        check("p4_static_channels", 64'(other_bad), 64'd0);

        // Mid-period reset with a pending shadow value.
        bus_wr(4'd8, 32'h08);
        repeat (10) @(negedge clk);
        reset = 1'b1; address = 4'd4;
        @(negedge clk);
        reset = 1'b0;
        #1 check("rst_status", 64'(readdata), 64'd0);
        check("rst_out_port", 64'(out_port), 64'hFF);
        check("rst_out_port4", 64'(out_port4), 64'hF);
        address = 4'd0;  #1 check("rst_data", 64'(readdata), 64'hFF);
        address = 4'd3;  #1 check("rst_mode", 64'(readdata), 64'h0);
        address = 4'd8;  #1 check("rst_duty0", 64'(readdata), 64'h0);
        repeat (5) @(negedge clk);
        check("rst_static_out", 64'(out_port), 64'hFF);

        bus_wr(4'd15, 32'hFFFF);
        address = 4'd15; #1 check("w4_addr15_reads0", 64'(readdata4), 64'h0);
        check("w8_addr15_duty7", 64'(readdata), 64'hF);
        address = 4'd0;  #1 check("w4_data_untouched", 64'(readdata4), 64'hF);
        bus_wr(4'd11, 32'h7);
        address = 4'd11; #1 check("w4_duty3_valid", 64'(readdata4), 64'h7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
